pcie_rx_symbol_aligner: RTL and testbench

PCIE_RX_SYMBOL_ALIGNER -- requirements
Module: pcie_rx_symbol_aligner

---
 rtl/pcie_rx_symbol_aligner_if.sv | 20 ++
 rtl/pcie_rx_symbol_aligner.sv | 77 +++++++
 tb/tb_pcie_rx_symbol_aligner.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pcie_rx_symbol_aligner_if.sv
// pcie_rx_symbol_aligner_if: decoded-symbol input bus and aligned-symbol output bus.
interface pcie_rx_symbol_aligner_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic [1:0]  in_charisk;
    logic [1:0]  in_err;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_charisk;
    logic [1:0]  out_err;
    logic [1:0]  out_skp;
    modport master (
        output in_valid, in_data, in_charisk, in_err,
        input  out_valid, out_data, out_charisk, out_err, out_skp
    );
    modport slave (
        input  in_valid, in_data, in_charisk, in_err,
        output out_valid, out_data, out_charisk, out_err, out_skp
    );
endinterface

// File: rtl/pcie_rx_symbol_aligner.sv
// pcie_rx_symbol_aligner: aligns a 2-symbol lane so COM lands in slot 0, tracks lock and symbol errors.
module pcie_rx_symbol_aligner #(
    parameter int ERR_LOCK_LIMIT = 4,
    parameter int ERR_CNT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    pcie_rx_symbol_aligner_if.slave  bus,
    input  logic                     err_count_clr,
    output logic                     locked,
    output logic                     phase,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);
    localparam int RW = $clog2(ERR_LOCK_LIMIT + 1);
    localparam int CW = ERR_CNT_WIDTH + 1;
    typedef enum logic {HUNT, LOCKED} state_t;
    state_t            state;
    logic [15:0]       prev_data, mux_data;
    logic [1:0]        prev_k, prev_e, mux_k, mux_e, mux_skp;
    logic [RW-1:0]     run, run_nxt;
    logic              com0, com1, phase_sel, lose, lock_now, stay;
    logic [CW-1:0]     err_sum;
    always_comb begin
        com0      = prev_k[0] && prev_data[7:0] == 8'hBC;
        com1      = prev_k[1] && prev_data[15:8] == 8'hBC;
        phase_sel = com0 ? 1'b0 : com1 ? 1'b1 : phase;
        run_nxt   = bus.in_err == 2'b00 ? '0 :
                    run == RW'(ERR_LOCK_LIMIT) ? run : run + RW'(1);
        lose      = state == LOCKED && run_nxt == RW'(ERR_LOCK_LIMIT);
        lock_now  = state == HUNT && (com0 || com1);
        stay      = state == LOCKED && !lose;
        mux_data  = phase_sel ? {bus.in_data[7:0], prev_data[15:8]} : prev_data;
        mux_k     = phase_sel ? {bus.in_charisk[0], prev_k[1]} : prev_k;
        mux_e     = phase_sel ? {bus.in_err[0], prev_e[1]} : prev_e;
        mux_skp   = {mux_k[1] && mux_data[15:8] == 8'h1C, mux_k[0] && mux_data[7:0] == 8'h1C};
        // clear takes effect first so a same-edge word still gets counted
        err_sum   = {1'b0, err_count_clr ? '0 : err_count}
                    + CW'(bus.in_err[0]) + CW'(bus.in_err[1]);
    end
    assign locked = state == LOCKED;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= HUNT;
            phase           <= 1'b0;
            prev_data       <= '0;
            prev_k          <= '0;
            prev_e          <= '0;
            run             <= '0;
            err_count       <= '0;
            bus.out_valid   <= 1'b0;
            bus.out_data    <= '0;
            bus.out_charisk <= '0;
            bus.out_err     <= '0;
            bus.out_skp     <= '0;
        end else begin
            bus.out_valid <= 1'b0;
            if (bus.in_valid) begin
                prev_data <= bus.in_data;
                prev_k    <= bus.in_charisk;
                prev_e    <= bus.in_err;
                run       <= lose ? '0 : run_nxt;
                phase     <= lose ? phase : phase_sel;
                state     <= (lock_now || stay) ? LOCKED : HUNT;
                err_count <= err_sum[CW-1] ? '1 : err_sum[CW-2:0];
                if (lock_now || stay) begin
                    bus.out_valid   <= 1'b1;
                    bus.out_data    <= mux_data;
                    bus.out_charisk <= mux_k;
                    bus.out_err     <= mux_e;
                    bus.out_skp     <= mux_skp;
                end
            end else if (err_count_clr) begin
                err_count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_pcie_rx_symbol_aligner.sv
// tb_pcie_rx_symbol_aligner: table-driven scoreboard bench plus hand sequences for gaps, counter saturation and reset.
module tb_pcie_rx_symbol_aligner;
    typedef struct {
        logic [15:0] d;
        logic [1:0]  k, e;
        logic        ev;
        logic [15:0] ed;
        logic [1:0]  ek, ee, es;
        logic        el, ep;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       locked, phase;
    logic [3:0] err_count;
    int         total = 0;
    int         bad = 0;
    vec_t       q[$];
    vec_t       tbl[20];

    pcie_rx_symbol_aligner_if bus();

    pcie_rx_symbol_aligner #(.ERR_LOCK_LIMIT(4), .ERR_CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .err_count_clr(clr),
        .locked(locked), .phase(phase), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [15:0] d, logic [1:0] k, logic [1:0] e, logic ev,
                                logic [15:0] ed, logic [1:0] ek, logic [1:0] ee,
                                logic [1:0] es, logic el, logic ep);
        vec_t t;
        t.d = d; t.k = k; t.e = e; t.ev = ev; t.ed = ed;
        t.ek = ek; t.ee = ee; t.es = es; t.el = el; t.ep = ep;
        return t;
    endfunction

    task automatic drive(logic v, logic [15:0] d, logic [1:0] k, logic [1:0] e, logic c);
        bus.in_valid   = v;
        bus.in_data    = d;
        bus.in_charisk = k;
        bus.in_err     = e;
        clr            = c;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        clr          = 1'b0;
    endtask

    task automatic apply(string tag, vec_t t);
        vec_t x;
        q.push_back(t);
        drive(1'b1, t.d, t.k, t.e, 1'b0);
        x = q.pop_front();
        chk({tag, " valid"}, 16'(bus.out_valid), 16'(x.ev));
        chk({tag, " locked"}, 16'(locked), 16'(x.el));
        chk({tag, " phase"}, 16'(phase), 16'(x.ep));
        if (x.ev) begin
            chk({tag, " data"}, bus.out_data, x.ed);
            chk({tag, " charisk"}, 16'(bus.out_charisk), 16'(x.ek));
            chk({tag, " err"}, 16'(bus.out_err), 16'(x.ee));
            chk({tag, " skp"}, 16'(bus.out_skp), 16'(x.es));
        end
    endtask

    initial begin
        // lock, SKP re-align, error-driven loss, relock, loss with COM on the same edge
        tbl[0]  = mk(16'h4ABC, 2'b01, 2'b00, 0, 16'h0000, 2'b00, 2'b00, 2'b00, 0, 0);
        tbl[1]  = mk(16'h4A4A, 2'b00, 2'b00, 1, 16'h4ABC, 2'b01, 2'b00, 2'b00, 1, 0);
        tbl[2]  = mk(16'h1CBC, 2'b11, 2'b00, 1, 16'h4A4A, 2'b00, 2'b00, 2'b00, 1, 0);
        tbl[3]  = mk(16'h4A1C, 2'b01, 2'b00, 1, 16'h1CBC, 2'b11, 2'b00, 2'b10, 1, 0);
        tbl[4]  = mk(16'hBC4A, 2'b10, 2'b00, 1, 16'h4A1C, 2'b01, 2'b00, 2'b01, 1, 0);
        tbl[5]  = mk(16'h4A4A, 2'b00, 2'b00, 1, 16'h4ABC, 2'b01, 2'b00, 2'b00, 1, 1);
        tbl[6]  = mk(16'h1111, 2'b00, 2'b00, 1, 16'h114A, 2'b00, 2'b00, 2'b00, 1, 1);
        tbl[7]  = mk(16'h2222, 2'b00, 2'b01, 1, 16'h2211, 2'b00, 2'b10, 2'b00, 1, 1);
        tbl[8]  = mk(16'h2222, 2'b00, 2'b01, 1, 16'h2222, 2'b00, 2'b10, 2'b00, 1, 1);
        tbl[9]  = mk(16'h2222, 2'b00, 2'b01, 1, 16'h2222, 2'b00, 2'b10, 2'b00, 1, 1);
        tbl[10] = mk(16'h2222, 2'b00, 2'b01, 0, 16'h0000, 2'b00, 2'b00, 2'b00, 0, 1);
        tbl[11] = mk(16'hBC00, 2'b10, 2'b00, 0, 16'h0000, 2'b00, 2'b00, 2'b00, 0, 1);
        tbl[12] = mk(16'h4A4A, 2'b00, 2'b00, 1, 16'h4ABC, 2'b01, 2'b00, 2'b00, 1, 1);
        tbl[13] = mk(16'h3333, 2'b00, 2'b01, 1, 16'h334A, 2'b00, 2'b10, 2'b00, 1, 1);
        tbl[14] = mk(16'h3333, 2'b00, 2'b01, 1, 16'h3333, 2'b00, 2'b10, 2'b00, 1, 1);
        tbl[15] = mk(16'h00BC, 2'b01, 2'b01, 1, 16'hBC33, 2'b10, 2'b10, 2'b00, 1, 1);
        tbl[16] = mk(16'h3333, 2'b00, 2'b01, 0, 16'h0000, 2'b00, 2'b00, 2'b00, 0, 1);
        tbl[17] = mk(16'h3333, 2'b00, 2'b00, 0, 16'h0000, 2'b00, 2'b00, 2'b00, 0, 1);
        tbl[18] = mk(16'h4ABC, 2'b01, 2'b00, 0, 16'h0000, 2'b00, 2'b00, 2'b00, 0, 1);
        tbl[19] = mk(16'h4A4A, 2'b00, 2'b00, 1, 16'h4ABC, 2'b01, 2'b00, 2'b00, 1, 0);

        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_charisk = '0; bus.in_err = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", 16'(bus.out_valid), 16'h0);
        chk("reset data", bus.out_data, 16'h0);
        chk("reset locked", 16'(locked), 16'h0);
        chk("reset phase", 16'(phase), 16'h0);
        chk("reset err_count", 16'(err_count), 16'h0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) apply($sformatf("w%0d", i), tbl[i]);
        chk("err_count after runs", 16'(err_count), 16'd8);

        // idle gap: no output, data held, alignment kept
        drive(1'b0, 16'hDEAD, 2'b11, 2'b11, 1'b0);
        chk("gap valid", 16'(bus.out_valid), 16'h0);
        chk("gap locked", 16'(locked), 16'h1);
        chk("gap data held", bus.out_data, 16'h4ABC);
        chk("gap err_count", 16'(err_count), 16'd8);
        apply("after gap", mk(16'h5555, 2'b00, 2'b00, 1, 16'h4A4A, 2'b00, 2'b00, 2'b00, 1, 0));

        // error counter: clear alone, saturate, clear with a counted word
        drive(1'b0, 16'h0, 2'b00, 2'b00, 1'b1);
        chk("clr alone", 16'(err_count), 16'd0);
        for (int i = 0; i < 7; i++) drive(1'b1, 16'h5555, 2'b00, 2'b11, 1'b0);
        chk("err_count 14", 16'(err_count), 16'd14);
        drive(1'b1, 16'h5555, 2'b00, 2'b11, 1'b0);
        chk("err_count sat", 16'(err_count), 16'd15);
        drive(1'b1, 16'h5555, 2'b00, 2'b11, 1'b0);
        chk("err_count hold sat", 16'(err_count), 16'd15);
        chk("err lock lost", 16'(locked), 16'h0);
        drive(1'b1, 16'h5555, 2'b00, 2'b11, 1'b1);
        chk("clr with word", 16'(err_count), 16'd2);

        // asynchronous reset while locked, then relock needs a fresh COM
        apply("pre-rst a", mk(16'h4ABC, 2'b01, 2'b00, 0, 16'h0, 2'b00, 2'b00, 2'b00, 0, 0));
        apply("pre-rst b", mk(16'h4A4A, 2'b00, 2'b00, 1, 16'h4ABC, 2'b01, 2'b00, 2'b00, 1, 0));
        #2 rst = 1'b1;
        #1;
        chk("async valid", 16'(bus.out_valid), 16'h0);
        chk("async data", bus.out_data, 16'h0);
        chk("async charisk", 16'(bus.out_charisk), 16'h0);
        chk("async locked", 16'(locked), 16'h0);
        chk("async err_count", 16'(err_count), 16'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        apply("post-rst a", mk(16'h4A4A, 2'b00, 2'b00, 0, 16'h0, 2'b00, 2'b00, 2'b00, 0, 0));
        apply("post-rst b", mk(16'h4ABC, 2'b01, 2'b00, 0, 16'h0, 2'b00, 2'b00, 2'b00, 0, 0));
        apply("post-rst c", mk(16'h1111, 2'b00, 2'b00, 1, 16'h4ABC, 2'b01, 2'b00, 2'b00, 1, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
